alu_op_sequencer: RTL and testbench

//  Multi-cycle controller that sequences the shared 32-bit ALU for one requester at a time.

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_wait_counter.sv | 32 +++
 rtl/alu_op_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the ALU op sequencer: op codes, FSM states,
// op legality and one-hot control decode.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_MUL = 4'd2,
    ALU_DIV = 4'd3,
    ALU_SHR = 4'd4,
    ALU_SHL = 4'd5,
    ALU_ROR = 4'd6,
    ALU_ROL = 4'd7,
    ALU_AND = 4'd8,
    ALU_OR  = 4'd9,
    ALU_NEG = 4'd10,
    ALU_NOT = 4'd11
  } alu_op_e;

  localparam int NUM_ALU_OPS = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return op < 4'(NUM_ALU_OPS);
  endfunction

  // Illegal codes decode to all-zero so the ALU is never driven for them.
  function automatic logic [NUM_ALU_OPS-1:0] op_onehot(input logic [3:0] op);
    logic [NUM_ALU_OPS-1:0] oh;
    oh = '0;
    if (op_legal(op)) oh[op] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/alu_wait_counter.sv
// Settle-time counter: loads on issue, counts down to zero without wrapping,
// and flags done while it sits at zero.
module alu_wait_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         clear_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences the shared ALU for one requester at a time: issue, wait the
// per-op settle time, capture zlow/zhigh, and hand the result back.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int BASIC_WAIT = 1,
  parameter int MUL_WAIT   = 4,
  parameter int DIV_WAIT   = 8
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [11:0] alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_zlow,
  input  logic [31:0] alu_zhigh,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_zlow,
  output logic [31:0] rsp_zhigh,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and a valid source holds its
  // payload stable until the transfer.

  localparam int MAX_WAIT_MB = (MUL_WAIT > BASIC_WAIT) ? MUL_WAIT : BASIC_WAIT;
  localparam int MAX_WAIT    = (DIV_WAIT > MAX_WAIT_MB) ? DIV_WAIT : MAX_WAIT_MB;
  localparam int CW          = $clog2(MAX_WAIT) + 1;

  function automatic logic [CW-1:0] wait_load(input logic [3:0] op);
    int w;
    case (op)
      ALU_MUL: w = MUL_WAIT;
      ALU_DIV: w = DIV_WAIT;
      default: w = BASIC_WAIT;
    endcase
    return CW'(w - 1);
  endfunction

  seq_state_e  state_q, state_d;
  logic [11:0] ctrl_q, ctrl_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] zlow_q, zlow_d, zhigh_q, zhigh_d;
  logic        err_q, err_d;
  logic        cnt_load, cnt_done;

  alu_wait_counter #(.W(CW)) u_wait_counter (
    .clock      (clock),
    .clear_n    (clear_n),
    .load_i     (cnt_load),
    .load_val_i (wait_load(req_op)),
    .dec_i      (state_q == WAIT),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    a_d      = a_q;
    b_d      = b_q;
    zlow_d   = zlow_q;
    zhigh_d  = zhigh_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (op_legal(req_op)) begin
            ctrl_d   = op_onehot(req_op);
            a_d      = req_a;
            b_d      = req_b;
            cnt_load = 1'b1;
            state_d  = WAIT;
          end else begin
            // Illegal op skips the ALU entirely and answers with an error.
            err_d   = 1'b1;
            zlow_d  = '0;
            zhigh_d = '0;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_done) begin
          zlow_d  = alu_zlow;
          zhigh_d = alu_zhigh;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          ctrl_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      zlow_q  <= '0;
      zhigh_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      zlow_q  <= zlow_d;
      zhigh_q <= zhigh_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign alu_ctrl  = ctrl_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_zlow  = zlow_q;
  assign rsp_zhigh = zhigh_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, directed vector table,
// reset-in-flight sequence and randomized ops against a reference model.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int BW = 1;
  localparam int MW = 4;
  localparam int DW = 8;

  logic        clock, clear_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [11:0] alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_zlow, alu_zhigh;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_zlow, rsp_zhigh;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.BASIC_WAIT(BW), .MUL_WAIT(MW), .DIV_WAIT(DW)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_ctrl  (alu_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_zlow  (alu_zlow),
    .alu_zhigh (alu_zhigh),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_zlow  (rsp_zlow),
    .rsp_zhigh (rsp_zhigh),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference ALU: returns {zhigh, zlow} ----------------
  function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic [63:0] aa;
    int s;
    s  = int'(b[4:0]);
    aa = {a, a};
    case (op)
      4'd0:  return {32'd0, a + b};
      4'd1:  return {32'd0, a - b};
      4'd2: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
      end
      4'd3: begin
        if (b == 32'd0) return 64'd0;
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
      4'd4:  return {32'd0, a >> s};
      4'd5:  return {32'd0, a << s};
      4'd6:  return {32'd0, 32'(aa >> s)};
      4'd7: begin
        aa = aa << s;
        return {32'd0, aa[63:32]};
      end
      4'd8:  return {32'd0, a & b};
      4'd9:  return {32'd0, a | b};
      4'd10: return {32'd0, 32'd0 - b};
      4'd11: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  // Behavioural ALU: junk unless the control is exactly one-hot.
  always_comb begin
    logic [63:0] r;
    r = 64'd0;
    alu_zlow  = 32'hDEAD_BEEF;
    alu_zhigh = 32'hBAD0_BAD0;
    for (int k = 0; k < 12; k++) begin
      if (alu_ctrl == (12'b1 << k)) begin
        r = alu_ref(4'(k), alu_a, alu_b);
        alu_zlow  = r[31:0];
        alu_zhigh = r[63:32];
      end
    end
  end

  function automatic int exp_latency(input logic [3:0] op);
    if (op > 4'd11) return 1;
    if (op == 4'd2) return MW + 1;
    if (op == 4'd3) return DW + 1;
    return BW + 1;
  endfunction

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: one full op with all timing checks ----------------
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit second, input bit early,
                        input logic [31:0] ezl, input logic [31:0] ezh,
                        input logic eerr, input int elat);
    logic [11:0] ectrl;
    int lat;
    ectrl = (op < 4'd12) ? (12'b1 << op) : 12'h000;
    @(negedge clock);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clock);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == 1) begin
        if (second) begin
          req_op = 4'd0; req_a = 32'd1; req_b = 32'd2;
        end else begin
          req_valid = 1'b0;
        end
        if (early) rsp_ready = 1'b1;
      end
      if (rsp_valid) begin
        lat = n;
        break;
      end
      check("wait_ctrl", alu_ctrl, ectrl);
      check("wait_a", alu_a, a);
      check("wait_b", alu_b, b);
      check("wait_ready_low", req_ready, 1'b0);
    end
    if (lat == 0) begin
      check("rsp_timeout", 1'b0, 1'b1);
      req_valid = 1'b0; rsp_ready = 1'b0;
      return;
    end
    check("latency", lat, elat);
    check("rsp_zlow", rsp_zlow, ezl);
    check("rsp_zhigh", rsp_zhigh, ezh);
    check("rsp_err", rsp_err, eerr);
    check("rsp_ctrl", alu_ctrl, ectrl);
    check("rsp_busy", busy, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_zlow", rsp_zlow, ezl);
      check("hold_zhigh", rsp_zhigh, ezh);
      check("hold_ctrl", alu_ctrl, ectrl);
      check("hold_a", alu_a, (op < 4'd12) ? a : alu_a);
      check("hold_ready_low", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("post_valid", rsp_valid, 1'b0);
    check("post_ready", req_ready, 1'b1);
    check("post_ctrl", alu_ctrl, 12'h000);
    check("post_busy", busy, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    int          hold;
    bit          second;
    logic [31:0] zl, zh;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] rr;
    bit          rearly;
    int          rhold;

    vecs[0] = '{4'd0,  32'd5,          32'd7,          0, 1'b0, 32'd12,         32'd0,          1'b0, 2};
    vecs[1] = '{4'd2,  32'hFFFF_FFFF,  32'd2,          0, 1'b0, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0, 5};
    vecs[2] = '{4'd3,  32'd17,         32'd5,          2, 1'b0, 32'd3,          32'd2,          1'b0, 9};
    vecs[3] = '{4'd13, 32'h1234_5678,  32'h9ABC_DEF0,  1, 1'b0, 32'd0,          32'd0,          1'b1, 1};
    vecs[4] = '{4'd8,  32'hF0F0_F0F0,  32'hFF00_FF00,  5, 1'b1, 32'hF000_F000,  32'd0,          1'b0, 2};
    vecs[5] = '{4'd0,  32'd1,          32'd2,          0, 1'b0, 32'd3,          32'd0,          1'b0, 2};
    vecs[6] = '{4'd7,  32'h8000_0001,  32'd1,          0, 1'b0, 32'h0000_0003,  32'd0,          1'b0, 2};
    vecs[7] = '{4'd10, 32'd99,         32'd1,          1, 1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 2};

    clear_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_ctrl", alu_ctrl, 12'h000);
    check("reset_alu_a", alu_a, 32'd0);
    check("reset_alu_b", alu_b, 32'd0);
    check("reset_zlow", rsp_zlow, 32'd0);
    check("reset_zhigh", rsp_zhigh, 32'd0);
    check("reset_err", rsp_err, 1'b0);
    check("reset_state", dbg_state, IDLE);
    clear_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].hold, vecs[v].second, 1'b0,
             vecs[v].zl, vecs[v].zh, vecs[v].err, vecs[v].lat);
    end

    // Reset in the middle of a MUL settle window.
    @(negedge clock);
    req_valid = 1'b1; req_op = 4'd2; req_a = 32'd3; req_b = 32'd4;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    check("mul_ctrl_before_reset", alu_ctrl, 12'h004);
    clear_n = 1'b0;
    #1;
    check("midreset_ctrl", alu_ctrl, 12'h000);
    check("midreset_rsp_valid", rsp_valid, 1'b0);
    check("midreset_req_ready", req_ready, 1'b1);
    check("midreset_busy", busy, 1'b0);
    @(negedge clock);
    clear_n = 1'b1;
    run_op(4'd0, 32'd1, 32'd1, 0, 1'b0, 1'b0, 32'd2, 32'd0, 1'b0, 2);

    // Randomized ops against the reference ALU model.
    for (int r = 0; r < 40; r++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (rop == 4'd3) rb = 32'($urandom_range(1, 1000));
      rearly = 1'($urandom_range(0, 1));
      rhold  = rearly ? 0 : $urandom_range(0, 3);
      rr = (rop < 4'd12) ? alu_ref(rop, ra, rb) : 64'd0;
      run_op(rop, ra, rb, rhold, 1'b0, rearly, rr[31:0], rr[63:32],
             (rop > 4'd11), exp_latency(rop));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
